// File: rtl/mccu.sv
// Multi-cycle control unit: Moore FSM sequencing IF/ID/EXE/MEM/WB with req/rdy memory.
// Define MCCU_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as nops.
module mccu #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:0]      op,
   input  logic             z,
   input  logic             mem_rdy,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_wen,
   output logic             pc_wen,
   output logic [1:0]       pcsource,
   output logic             cu_wreg,
   output logic             cu_m2reg,
   output logic             cu_shift,
   output logic             cu_aluimm,
   output logic             cu_sext,
   output logic             cu_sst,
   output logic [3:0]       cu_aluc,
   output logic [2:0]       state_o,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EXE  = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_TRAP = 3'd7;

   logic [2:0] state, state_nx;
   logic       retire;

   logic [5:0] opc, fn;
   logic       is_r, is_i, is_lw, is_sw;
   logic       is_beq, is_bne, is_j, is_legal;
   logic       is_addi;
   logic [3:0] aluc_d;

   assign opc     = op[11:6];
   assign fn      = op[5:0];
   assign state_o = state;

   // Instruction decode, independent of state
   always_comb begin
      is_r    = 1'b0;
      is_i    = 1'b0;
      is_addi = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_beq  = 1'b0;
      is_bne  = 1'b0;
      is_j    = 1'b0;
      aluc_d  = 4'b0000;
      case (opc)
         6'b000000: begin
            is_r = (fn == 6'b000001);
         end
         6'b000001: begin
            case (fn)
               6'b000001: begin is_r = 1'b1; aluc_d = 4'b0010; end
               6'b000010: begin is_r = 1'b1; aluc_d = 4'b0011; end
               6'b000100: begin is_r = 1'b1; aluc_d = 4'b0100; end
               default:   is_r = 1'b0;
            endcase
         end
         6'b000010: begin
            case (fn)
               6'b000001: begin is_r = 1'b1; aluc_d = 4'b1110; end
               6'b000010: begin is_r = 1'b1; aluc_d = 4'b1100; end
               6'b000011: begin is_r = 1'b1; aluc_d = 4'b1000; end
               default:   is_r = 1'b0;
            endcase
         end
         6'b000101: begin is_i = 1'b1; is_addi = 1'b1; end
         6'b001001: begin is_i = 1'b1; aluc_d = 4'b0010; end
         6'b001010: begin is_i = 1'b1; aluc_d = 4'b0011; end
         6'b001100: begin is_i = 1'b1; aluc_d = 4'b0100; end
         6'b001101: is_lw = 1'b1;
         6'b001110: is_sw = 1'b1;
         6'b001111: begin is_beq = 1'b1; aluc_d = 4'b0001; end
         6'b010000: begin is_bne = 1'b1; aluc_d = 4'b0001; end
         6'b010001: is_j = 1'b1;
         default:   is_r = 1'b0;
      endcase
      is_legal = is_r | is_i | is_lw | is_sw | is_beq | is_bne | is_j;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IF;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      case (state)
         S_IF: begin
            if (mem_rdy)
               state_nx = S_ID;
         end
         S_ID: begin
            if (is_j) begin
               state_nx = S_IF;
               retire   = 1'b1;
            end else if (!is_legal) begin
`ifdef MCCU_ILLEGAL_TRAP_EN
               state_nx = S_TRAP;
`else
               state_nx = S_IF;
               retire   = 1'b1;
`endif
            end else begin
               state_nx = S_EXE;
            end
         end
         S_EXE: begin
            if (is_beq | is_bne) begin
               state_nx = S_IF;
               retire   = 1'b1;
            end else if (is_lw | is_sw) begin
               state_nx = S_MEM;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM: begin
            if (mem_rdy) begin
               if (is_sw) begin
                  state_nx = S_IF;
                  retire   = 1'b1;
               end else begin
                  state_nx = S_WB;
               end
            end
         end
         S_WB: begin
            state_nx = S_IF;
            retire   = 1'b1;
         end
`ifdef MCCU_ILLEGAL_TRAP_EN
         S_TRAP: state_nx = S_TRAP;
`endif
         default: state_nx = S_IF;
      endcase
   end

   // Decode-driven controls only apply once the IR is stable past ID
   always_comb begin
      logic dec_on;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_wen    = 1'b0;
      pc_wen    = 1'b0;
      pcsource  = 2'b00;
      cu_wreg   = 1'b0;
      cu_m2reg  = 1'b0;
      cu_shift  = 1'b0;
      cu_aluimm = 1'b0;
      cu_sext   = 1'b0;
      cu_sst    = 1'b0;
      cu_aluc   = 4'b0000;
      trap      = 1'b0;
      dec_on    = (state == S_EXE) | (state == S_MEM) | (state == S_WB);
      if (dec_on) begin
         cu_aluc   = aluc_d;
         cu_aluimm = is_i | is_lw | is_sw;
         cu_shift  = (opc == 6'b000010);
         cu_sext   = is_addi | is_lw | is_sw | is_beq | is_bne;
         cu_sst    = is_i | is_lw;
         cu_m2reg  = is_lw;
      end
      case (state)
         S_IF: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               ir_wen = 1'b1;
               pc_wen = 1'b1;
            end
         end
         S_ID: begin
            if (is_j) begin
               pc_wen   = 1'b1;
               pcsource = 2'b11;
            end
         end
         S_EXE: begin
            if ((is_beq & z) | (is_bne & ~z)) begin
               pc_wen   = 1'b1;
               pcsource = 2'b01;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = is_sw;
         end
         S_WB: cu_wreg = 1'b1;
`ifdef MCCU_ILLEGAL_TRAP_EN
         S_TRAP: trap = 1'b1;
`endif
         default: trap = 1'b0;
      endcase
   end

endmodule

// File: doc/mccu.md
Name: mccu

Overview:
- Multi-cycle control unit for the 12-bit-op CPU. `op[11:6]` is the opcode and `op[5:0]` is the function field.
- A Moore FSM steps the shared datapath (one ALU, one unified memory port) through IF/ID/EXE/MEM/WB.
- Memory accesses use a req/rdy handshake.
- Drives the same `cu_*` control set as the single-cycle unit, plus PC/IR enables, address select and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- op  in  12  instruction from the IR; valid from ID onward
- z  in  1  ALU zero flag
- mem_rdy  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (store)
- iord  out  1  memory address source: PC (0), ALU result reg (1)
- ir_wen  out  1  load IR from memory read data
- pc_wen  out  1  PC write enable
- pcsource  out  2  PC input select: 00 PC+4, 01 branch target, 11 jump target
- cu_wreg, cu_m2reg, cu_shift, cu_aluimm, cu_sext, cu_sst  out  1 each  same meaning as single-cycle control
- cu_aluc  out  4  ALU operation
- state_o  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, TRAP=7
- trap  out  1  illegal-instruction trap
- retired  out  CNT_W  instructions completed; wraps to 0

Behaviour:
- Outputs are combinational from the state register and `op` (Moore plus decode). Only `state` and `retired` are registered.
- Reset (rst=1 at an edge): state=IF, retired=0, trap=0. Reset overrides every transition.
  - Reset mid-MEM aborts the access: no register write, no PC change, next state IF.
- Default in every state: all outputs 0 unless listed below.
- Decode classes:
  - R: op=000000/000001 add; 000001/{000001 and, 000010 or, 000100 xor}; 000010/{000001,000010,000011} shifts.
  - I: 000101 addi, 001001 andi, 001010 ori, 001100 xori.
  - LW 001101; SW 001110; BEQ 001111; BNE 010000; J 010001.
  - Anything else is illegal.
- cu_aluc encodings:
  - 0000: add, addi, lw, sw
  - 0001: beq, bne
  - 0010: and, andi
  - 0011: or, ori
  - 0100: xor, xori
  - Shifts by func 000001/000010/000011: 1110/1100/1000
- Decode signals, valid in EXE, MEM and WB (0 in IF/ID):
  - cu_aluc as above.
  - cu_aluimm=1 for I/LW/SW.
  - cu_shift=1 when op[11:6]=000010.
  - cu_sext=1 for addi/LW/SW/BEQ/BNE.
  - cu_sst=1 for I/LW.
  - cu_m2reg=1 for LW.
- IF:
  - mem_req=1, iord=0.
  - While mem_rdy=0: hold state.
  - On mem_rdy=1: ir_wen=1, pc_wen=1, pcsource=00; next state ID.
- ID:
  - J: pc_wen=1, pcsource=11; next IF; retire.
  - Illegal: next IF; retire (treated as nop).
  - Otherwise: next EXE.
- EXE:
  - BEQ with z=1, or BNE with z=0: pc_wen=1, pcsource=01.
  - Branches (taken or not): next IF; retire.
  - LW/SW: next MEM.
  - R/I: next WB.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for SW only.
  - While mem_rdy=0: hold state; outputs held stable.
  - On mem_rdy=1: SW goes to IF and retires; LW goes to WB.
- WB:
  - cu_wreg=1 for exactly one cycle.
  - Next IF; retire.
- Retire: `retired` increments by 1 at the edge leaving the final state of an instruction; CNT_W-bit wrap from all-ones to 0.
- Latency with zero-wait memory (mem_rdy tied 1):
  - J and illegal: 2 cycles.
  - Branch: 3 cycles.
  - R/I and SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds 1 to the instruction's latency.
- pc_wen asserts at most once per state visit.
  - In IF, pc_wen asserts only in the mem_rdy cycle.
  - A PC+4 update in IF and a branch/jump update in EXE/ID never coincide.

Optional Feature:
- Macro MCCU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal op in ID goes to TRAP instead of IF, with no retire.
  - TRAP: trap=1, all other control outputs 0; the state is held until rst.
- Undefined:
  - An illegal op is a nop as described in Behaviour.
  - The TRAP state is unreachable and trap is tied to 0.

Test Plan:
- rst=1 for 2 cycles, then released with mem_rdy=1 → first cycle: state_o=0, mem_req=1, retired=0, trap=0; ir_wen=1 and pc_wen=1 in the same cycle.
- mem_rdy=1, op=000000000001 (add) → states 0,1,2,4; cu_aluc=0000 in EXE; cu_wreg=1 only in WB; retired 0→1 after 4 cycles.
- LW (op[11:6]=001101) with mem_rdy low for 3 cycles in MEM → MEM held 4 cycles with iord=1, mem_we=0; WB has cu_m2reg=1, cu_sst=1, cu_wreg=1; total 8 cycles.
- BEQ with z=1, then BEQ with z=0 → first: EXE pc_wen=1, pcsource=01; second: pc_wen=0 in EXE; each retires after 3 cycles.
- SW (001110), rst asserted during the 2nd MEM wait cycle → mem_we=1 until reset; next cycle state_o=0, retired=0, no cu_wreg pulse.
- Illegal op[11:6]=111111 → without macro: returns to IF after ID, retired+1. With MCCU_ILLEGAL_TRAP_EN: state_o=7, trap=1 held 10 cycles, retired unchanged; rst returns state_o to 0.
